// File: rtl/lpf_pkg.sv
// -----------------------------------------------------------------------------
// lpf_pkg
// Shared definitions for the multichannel low-pass filter path.
//   - FSM state encoding (2-bit) used by lpf_multichannel
//   - calc_acc_w(): accumulator width from input width and guard bits
//   - default data widths shared with the ADC and DAC drivers
// -----------------------------------------------------------------------------
package lpf_pkg;

    // Widths agreed with the neighbouring converter drivers.
    localparam int ADC_W      = 14;
    localparam int DAC_W      = 12;
    localparam int DEF_FRAC_W = 6;

    // Sequencer states; the encoding is fixed so it can be probed on a bus.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_PROC    = 2'd2,
        ST_DONE    = 2'd3
    } lpf_state_e;

    // Accumulator keeps the full input plus fractional guard bits below it.
    function automatic int calc_acc_w(input int din_w, input int frac_w);
        return din_w + frac_w;
    endfunction

endpackage

// File: rtl/lpf_update_core.sv
// -----------------------------------------------------------------------------
// lpf_update_core
// Purely combinational single-channel update of a first-order IIR low-pass:
//   y_next = y + ((x << FRAC_W) - y) >>> k
// or, when PRELOAD is enabled and the channel has not seen a sample yet,
//   y_next = x << FRAC_W.
// Ports:
//   y_i            current accumulator (signed, ACC_W)
//   x_i            new input sample (signed, DIN_W)
//   k_i            shift amount (unsigned, K_W)
//   init_pending_i channel still waiting for its first sample
//   y_next_o       updated accumulator (signed, ACC_W)
// -----------------------------------------------------------------------------
module lpf_update_core
    import lpf_pkg::*;
#(
    parameter int DIN_W   = ADC_W,
    parameter int FRAC_W  = DEF_FRAC_W,
    parameter int K_W     = 4,
    parameter int PRELOAD = 1
) (
    input  logic signed [DIN_W+FRAC_W-1:0] y_i,
    input  logic signed [DIN_W-1:0]        x_i,
    input  logic        [K_W-1:0]          k_i,
    input  logic                           init_pending_i,
    output logic signed [DIN_W+FRAC_W-1:0] y_next_o
);

    localparam int ACC_W = calc_acc_w(DIN_W, FRAC_W);

    logic signed [ACC_W-1:0] xe_s;
    logic signed [ACC_W:0]   diff_s;
    logic        [31:0]      k_ext_s;
    logic        [31:0]      shamt_s;

    // Input scaled onto the accumulator grid; the extra bit on diff avoids overflow.
    assign xe_s    = {x_i, {FRAC_W{1'b0}}};
    assign diff_s  = {xe_s[ACC_W-1], xe_s} - {y_i[ACC_W-1], y_i};

    // Any shift of ACC_W or more already collapses diff to 0 or -1.
    assign k_ext_s = 32'(k_i);
    assign shamt_s = (k_ext_s > 32'(ACC_W)) ? 32'(ACC_W) : k_ext_s;

    // Select preload or the filtered step; the low ACC_W bits of y + step are exact
    // because the result is a convex combination of y and xe.
    always_comb begin
        y_next_o = y_i;
        if ((PRELOAD == 1) && init_pending_i) begin
            y_next_o = xe_s;
        end else begin
            y_next_o = y_i + ACC_W'(diff_s >>> shamt_s);
        end
    end

endmodule

// File: rtl/lpf_multichannel.sv
// -----------------------------------------------------------------------------
// lpf_multichannel
// N_CH independent exponential low-pass filters sharing one update core,
// processed one channel per clock after each accepted sample.
// Ports:
//   qzt_clk       system clock
//   rst_n         synchronous reset, active low
//   sample_valid  strobe; din, k and hold are captured while sample_ready=1
//   sample_ready  high while idle
//   din           packed signed samples, channel 0 in the LSBs
//   k             shift amount for this sample
//   hold          freeze accumulators for this sample (dout_valid still pulses)
//   clear         synchronous clear of accumulators, init flags and overrun
//   dout          packed signed accumulators, channel 0 in the LSBs
//   dout_valid    one-cycle strobe once all channels are updated
//   overrun       sticky: strobe arrived while busy
// -----------------------------------------------------------------------------
module lpf_multichannel
    import lpf_pkg::*;
#(
    parameter int N_CH    = 2,
    parameter int DIN_W   = ADC_W,
    parameter int FRAC_W  = DEF_FRAC_W,
    parameter int K_W     = 4,
    parameter int PRELOAD = 1
) (
    input  logic                             qzt_clk,
    input  logic                             rst_n,
    input  logic                             sample_valid,
    output logic                             sample_ready,
    input  logic [N_CH*DIN_W-1:0]            din,
    input  logic [K_W-1:0]                   k,
    input  logic                             hold,
    input  logic                             clear,
    output logic [N_CH*(DIN_W+FRAC_W)-1:0]   dout,
    output logic                             dout_valid,
    output logic                             overrun
);

    localparam int ACC_W = calc_acc_w(DIN_W, FRAC_W);
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

    lpf_state_e              state_q, state_d;
    logic [CH_W-1:0]         ch_idx_q, ch_idx_d;
    logic                    sample_ready_q;
    logic                    dout_valid_q;
    logic                    overrun_q;
    logic signed [DIN_W-1:0] din_q [N_CH];
    logic [K_W-1:0]          k_q;
    logic                    hold_q;
    logic signed [ACC_W-1:0] acc_q [N_CH];
    logic [N_CH-1:0]         init_q;

    logic                    accept_s;
    logic                    upd_en_s;
    logic signed [ACC_W-1:0] y_next_s;

    // Sequencer next state: capture, walk the channels, then announce the result.
    always_comb begin
        state_d  = state_q;
        ch_idx_d = ch_idx_q;
        accept_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sample_valid) begin
                    accept_s = 1'b1;
                    state_d  = ST_CAPTURE;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                ch_idx_d = '0;
                state_d  = ST_PROC;
            end
            ST_PROC: begin
                if (ch_idx_q == LAST_CH) begin
                    state_d  = ST_DONE;
                end else begin
                    ch_idx_d = ch_idx_q + CH_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign upd_en_s = (state_q == ST_PROC) && !hold_q;

    lpf_update_core #(
        .DIN_W   (DIN_W),
        .FRAC_W  (FRAC_W),
        .K_W     (K_W),
        .PRELOAD (PRELOAD)
    ) u_core (
        .y_i            (acc_q[ch_idx_q]),
        .x_i            (din_q[ch_idx_q]),
        .k_i            (k_q),
        .init_pending_i (init_q[ch_idx_q]),
        .y_next_o       (y_next_s)
    );

    // Control registers; clear outranks everything except reset and aborts the sample.
    always_ff @(posedge qzt_clk) begin
        if (!rst_n || clear) begin
            state_q        <= ST_IDLE;
            ch_idx_q       <= '0;
            sample_ready_q <= 1'b1;
            dout_valid_q   <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            ch_idx_q       <= ch_idx_d;
            sample_ready_q <= (state_d == ST_IDLE);
            dout_valid_q   <= (state_d == ST_DONE);
            if (sample_valid && !sample_ready_q) begin
                overrun_q <= 1'b1;
            end
        end
    end

    // Sample latch and accumulator array; one channel written per PROC cycle.
    always_ff @(posedge qzt_clk) begin
        if (!rst_n || clear) begin
            for (int i = 0; i < N_CH; i++) begin
                acc_q[i] <= '0;
                din_q[i] <= '0;
            end
            init_q <= '1;
            k_q    <= '0;
            hold_q <= 1'b0;
        end else begin
            if (accept_s) begin
                for (int i = 0; i < N_CH; i++) begin
                    din_q[i] <= din[i*DIN_W +: DIN_W];
                end
                k_q    <= k;
                hold_q <= hold;
            end
            if (upd_en_s) begin
                acc_q[ch_idx_q]  <= y_next_s;
                init_q[ch_idx_q] <= 1'b0;
            end
        end
    end

    // Accumulators are visible continuously; dout_valid marks a complete vector.
    always_comb begin
        dout = '0;
        for (int i = 0; i < N_CH; i++) begin
            dout[i*ACC_W +: ACC_W] = acc_q[i];
        end
    end

    assign sample_ready = sample_ready_q;
    assign dout_valid   = dout_valid_q;
    assign overrun      = overrun_q;

endmodule
